// File: rtl/win3x3_gen_pkg.sv
// Shared definitions for the 3x3 window generator and its consumers.
package win3x3_gen_pkg;

  // Window geometry; the downstream adder tree is instantiated with N = WIN_N.
  localparam int WIN_DIM = 3;
  localparam int WIN_N   = WIN_DIM * WIN_DIM;

  // Flat element index used on the packed window bus: k = r*3 + c.
  function automatic int win_idx(input int r, input int c);
    return r * WIN_DIM + c;
  endfunction

endpackage : win3x3_gen_pkg

// File: rtl/win3x3_gen_linebuf_ram.sv
// Single-line pixel buffer: one synchronous write port, one asynchronous read port.
module linebuf_ram
  import win3x3_gen_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int W     = 10,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Write the accepted pixel into its column slot.
  // NOTE: the storage array has no reset; its contents are stale until a line
  // has been written, and the window logic never emits data that depends on it.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Asynchronous read so the old column value is seen before this edge's write.
  assign rdata_o = mem_q[raddr_i];

endmodule : linebuf_ram

// File: rtl/win3x3_gen.sv
// Raster pixel stream to 3x3 neighbourhood windows (fully interior windows only).
module win3x3_gen
  import win3x3_gen_pkg::*;
#(
  parameter int W     = 10,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  localparam int XW   = $clog2(IMG_W),
  localparam int YW   = $clog2(IMG_H)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_sof,
  input  logic [W-1:0]       in_data,
  output logic               out_valid,
  output logic [WIN_N*W-1:0] out_win,
  output logic [XW-1:0]      out_cx,
  output logic [YW-1:0]      out_cy
);

  // Position of the next accepted pixel.
  logic [XW-1:0] x_q, x_d, x_cur;
  logic [YW-1:0] y_q, y_d, y_cur;

  // Window register array: [row][col], row 0 = oldest line, col 0 = oldest column.
  logic [W-1:0] win_q [WIN_DIM][WIN_DIM];
  logic [W-1:0] win_d [WIN_DIM][WIN_DIM];

  // Registered outputs.
  logic               out_valid_q;
  logic [WIN_N*W-1:0] out_win_q, out_win_d;
  logic [XW-1:0]      out_cx_q;
  logic [YW-1:0]      out_cy_q;

  // Line buffer taps: lb1 holds row y-2, lb0 holds row y-1.
  logic [W-1:0] lb0_rdata, lb1_rdata;
  logic         emit;

  linebuf_ram #(.DEPTH(IMG_W), .W(W)) lb0 (
    .clk     (clk),
    .we_i    (in_valid),
    .waddr_i (x_cur),
    .wdata_i (in_data),
    .raddr_i (x_cur),
    .rdata_o (lb0_rdata)
  );

  // lb1 receives the value lb0 is about to overwrite, shifting the column down one line.
  linebuf_ram #(.DEPTH(IMG_W), .W(W)) lb1 (
    .clk     (clk),
    .we_i    (in_valid),
    .waddr_i (x_cur),
    .wdata_i (lb0_rdata),
    .raddr_i (x_cur),
    .rdata_o (lb1_rdata)
  );

  // Effective pixel position, next position and the emit decision for this pixel.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    x_cur = in_sof ? '0 : x_q;
    y_cur = in_sof ? '0 : y_q;
    x_d   = x_cur + XW'(1);
    y_d   = y_cur;
    if (x_cur == XW'(IMG_W - 1)) begin
      x_d = '0;
      y_d = (y_cur == YW'(IMG_H - 1)) ? '0 : y_cur + YW'(1);
    end
    // Columns 0 and 1 of a line only refill the window; rows 0 and 1 only fill buffers.
    emit = in_valid && (x_cur >= XW'(2)) && (y_cur >= YW'(2));
  end

  // Next window: shift one column left, new column {lb1, lb0, pixel} enters at c=2.
  always_comb begin
    for (int r = 0; r < WIN_DIM; r++) begin
      for (int c = 0; c < WIN_DIM - 1; c++) begin
        win_d[r][c] = win_q[r][c+1];
      end
    end
    win_d[0][WIN_DIM-1] = lb1_rdata;
    win_d[1][WIN_DIM-1] = lb0_rdata;
    win_d[2][WIN_DIM-1] = in_data;
  end

  // Pack the next window onto the flat bus, element k at [k*W +: W].
  always_comb begin
    out_win_d = '0;
    for (int r = 0; r < WIN_DIM; r++) begin
      for (int c = 0; c < WIN_DIM; c++) begin
        out_win_d[win_idx(r, c)*W +: W] = win_d[r][c];
      end
    end
  end

  // Counters, window array and output register, all advanced on an accepted pixel.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q         <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      out_win_q   <= '0;
      out_cx_q    <= '0;
      out_cy_q    <= '0;
      for (int r = 0; r < WIN_DIM; r++) begin
        for (int c = 0; c < WIN_DIM; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      out_valid_q <= emit;
      if (in_valid) begin
        x_q   <= x_d;
        y_q   <= y_d;
        win_q <= win_d;
      end
      if (emit) begin
        out_win_q <= out_win_d;
        out_cx_q  <= x_cur - XW'(1);
        out_cy_q  <= y_cur - YW'(1);
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_win   = out_win_q;
  assign out_cx    = out_cx_q;
  assign out_cy    = out_cy_q;

endmodule : win3x3_gen
